// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared constants for the RISC-V core front end: datapath width, default
//   reset PC, major opcodes seen by the control decoder, and the fetch-stage
//   state encoding.
//   No ports (package).
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Major opcodes (instr[6:0]) consumed by the control decoder.
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // FETCH: nothing outstanding.
    // WAIT : one request outstanding, its word will be kept.
    // DROP : one request outstanding, its word belongs to a flushed path.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
//   Bundles the fetch stage's three bus-like connections:
//     imem side   : imem_req, imem_addr (out) / imem_rvalid, imem_rdata (in)
//     execute side: redirect, redirect_pc (in)
//     decode side : id_ready (in) / if_valid, if_pc, if_instr, if_opcode (out)
//   modport master : the fetch stage
//   modport slave  : the surroundings (imem, execute, decode)
// -----------------------------------------------------------------------------
interface instr_fetch_if #(
    parameter int XLEN = riscv_pkg::XLEN
);

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    logic            id_ready;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;
    logic [6:0]      if_opcode;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_instr, if_opcode,
        input  imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_instr, if_opcode,
        output imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Two-entry {pc, instr} queue between instruction memory and decode.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     push_i, push_pc_i,
//     push_instr_i             enqueue one entry
//     pop_i                    dequeue head (only asserted when count_o != 0)
//     flush_i                  drop all entries (wins over push/pop)
//     count_o                  occupancy 0..2
//     head_pc_o, head_instr_o  head entry; hold until pop, push-into-empty
//                              or reset
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic [XLEN-1:0] push_pc_i,
    input  logic [31:0]     push_instr_i,
    input  logic            pop_i,
    input  logic            flush_i,
    output logic [1:0]      count_o,
    output logic [XLEN-1:0] head_pc_o,
    output logic [31:0]     head_instr_o
);

    logic [1:0]      count_q, count_d;
    logic [XLEN-1:0] head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
    logic [31:0]     head_instr_q, head_instr_d, tail_instr_q, tail_instr_d;

    always_comb begin
        // NOTE: every next-state value gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        count_d      = count_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        tail_pc_d    = tail_pc_q;
        tail_instr_d = tail_instr_q;

        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b01: begin
                    head_pc_d    = tail_pc_q;
                    head_instr_d = tail_instr_q;
                    count_d      = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_pc_d    = push_pc_i;
                        head_instr_d = push_instr_i;
                    end else begin
                        tail_pc_d    = push_pc_i;
                        tail_instr_d = push_instr_i;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word lands behind
                    // whatever survives the pop.
                    if (count_q == 2'd2) begin
                        head_pc_d    = tail_pc_q;
                        head_instr_d = tail_instr_q;
                        tail_pc_d    = push_pc_i;
                        tail_instr_d = push_instr_i;
                    end else begin
                        head_pc_d    = push_pc_i;
                        head_instr_d = push_instr_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage is only two registers, and resetting it makes an empty queue present pc/instr of zero to decode.
            count_q      <= 2'd0;
            head_pc_q    <= '0;
            head_instr_q <= '0;
            tail_pc_q    <= '0;
            tail_instr_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            count_q      <= count_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            tail_pc_q    <= tail_pc_d;
            tail_instr_q <= tail_instr_d;
        end
    end

    assign count_o      = count_q;
    assign head_pc_o    = head_pc_q;
    assign head_instr_o = head_instr_q;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction-fetch stage: owns the PC, issues one-word reads to instruction
//   memory (at most one outstanding), buffers returned words in a 2-entry
//   queue and presents {pc, instr} to decode. A redirect from execute flushes
//   the queue and restarts fetch at redirect_pc (word aligned).
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous, active-high reset (imem shares it)
//     bus   instr_fetch_if.master: imem_req/imem_addr/imem_rvalid/imem_rdata,
//           redirect/redirect_pc, id_ready/if_valid/if_pc/if_instr/if_opcode
// -----------------------------------------------------------------------------
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_if.master        bus
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pend_pc_q;   // PC of the outstanding request

    logic [1:0]      q_count;
    logic [XLEN-1:0] head_pc;
    logic [31:0]     head_instr;

    logic            pending;
    logic            pop;
    logic            push;
    logic            one_out_ok;
    logic [2:0]      occ_after;
    logic            issue;

    assign pending = (state_q != ST_FETCH);
    assign pop     = (q_count != 2'd0) && bus.id_ready && !bus.redirect;
    assign push    = bus.imem_rvalid && (state_q == ST_WAIT) && !bus.redirect;

    // A response only moves a slot from "pending" into the queue, so it
    // frees no space; only a pop does. Counting the outstanding request as
    // occupied guarantees its word always has a slot when it returns.
    assign occ_after = {1'b0, q_count} + {2'b00, pending} - {2'b00, pop};

    // Keep at most one request in flight: issue only when nothing is pending
    // or the pending one retires this very cycle. That includes the stale
    // response in DROP, so the redirect target goes out as it arrives.
    assign one_out_ok = (state_q == ST_FETCH) || bus.imem_rvalid;
    assign issue      = !bus.redirect && !rst && one_out_ok && (occ_after < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            pend_pc_q <= '0;
        end else if (bus.redirect) begin
            pc_q <= bus.redirect_pc & ~XLEN'(3);
            // An in-flight word that has not returned yet must be discarded.
            if (state_q == ST_FETCH || bus.imem_rvalid) begin
                state_q <= ST_FETCH;
            end else begin
                state_q <= ST_DROP;
            end
        end else begin
            if (issue) begin
                pc_q      <= pc_q + XLEN'(4);
                pend_pc_q <= pc_q;
                state_q   <= ST_WAIT;
            end else if (bus.imem_rvalid) begin
                state_q <= ST_FETCH;
            end
        end
    end

    fetch_fifo #(.XLEN(XLEN)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_pc_i    (pend_pc_q),
        .push_instr_i (bus.imem_rdata),
        .pop_i        (pop),
        .flush_i      (bus.redirect),
        .count_o      (q_count),
        .head_pc_o    (head_pc),
        .head_instr_o (head_instr)
    );

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = (q_count != 2'd0);
    assign bus.if_pc     = head_pc;
    assign bus.if_instr  = head_instr;
    assign bus.if_opcode = head_instr[6:0];

    // A kept response arriving into a full queue that is not draining would
    // lose a word; the credit logic above must make this unreachable.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (q_count == 2'd2) && !pop));

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Drives instr_fetch through its interface with an instruction-memory model
//   of configurable latency, stalls from decode, redirects and resets.
//   Expected fetch stream: PCs run sequentially (+4, wrapping) from the reset
//   PC or from each redirect target; each word is mem_word(pc). The driver
//   keeps a queue of upcoming expected entries; a monitor compares the head
//   entry presented to decode and pops on every accepted transfer.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_fetch_if #(.XLEN(32)) bus ();

    instr_fetch #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int lat    = 1;       // memory latency; 0 selects random 1..4 per request
    int pops   = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mem_q[$];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] next_exp_pc;
    bit          req_chk_en = 1'b0;
    logic [31:0] req_chk_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic top_up();
        exp_t e;
        while (exp_q.size() < 4) begin
            e.pc    = next_exp_pc;
            e.instr = mem_word(next_exp_pc);
            exp_q.push_back(e);
            next_exp_pc = next_exp_pc + 32'd4;
        end
    endtask

    // Fetch restarts at target (aligned); the next request must go there.
    task automatic model_restart(input logic [31:0] target);
        exp_q.delete();
        next_exp_pc  = target & ~32'h3;
        req_chk_en   = 1'b1;
        req_chk_addr = target & ~32'h3;
        top_up();
    endtask

    // Advance one clock; drive memory responses that fall due this cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        bus.imem_rvalid = 1'b0;
        if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        top_up();
    endtask

    task automatic start_reset();
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.imem_rvalid = 1'b0;
        mem_q.delete();
        model_restart(RST_PC);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_imem_req"},  32'(bus.imem_req),  32'd0);
        check({tag, "_if_valid"},  32'(bus.if_valid),  32'd0);
        check({tag, "_if_pc"},     bus.if_pc,          32'd0);
        check({tag, "_if_instr"},  bus.if_instr,       32'd0);
        check({tag, "_if_opcode"}, 32'(bus.if_opcode), 32'd0);
    endtask

    task automatic wait_req_seen(input string name, input int budget);
        int n = 0;
        while (req_chk_en && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(req_chk_en), 32'd0);
    endtask

    // Memory side: capture requests, check restart addresses and the
    // single-outstanding rule.
    always @(negedge clk) begin
        mreq_t r;
        if (!rst && bus.imem_req) begin
            if (req_chk_en) begin
                check("restart_req_addr", bus.imem_addr, req_chk_addr);
                req_chk_en = 1'b0;
            end
            check("req_addr_align", {30'd0, bus.imem_addr[1:0]}, 32'd0);
            r.addr = bus.imem_addr;
            r.due  = cyc + ((lat == 0) ? int'($urandom_range(1, 4)) : lat);
            mem_q.push_back(r);
            check("one_outstanding", 32'(mem_q.size()), 32'd1);
        end
    end

    // Decode side: head entry against the expected stream.
    always @(negedge clk) begin
        if (!rst && !bus.redirect && bus.if_valid) begin
            if (exp_q.size() == 0) begin
                check("exp_queue_empty", 32'd1, 32'd0);
            end else begin
                check("if_pc",     bus.if_pc,          exp_q[0].pc);
                check("if_instr",  bus.if_instr,       exp_q[0].instr);
                check("if_opcode", 32'(bus.if_opcode), {25'd0, exp_q[0].instr[6:0]});
                if (bus.id_ready) begin
                    void'(exp_q.pop_front());
                    pops++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit found;
        int rst_left;
        int p0;

        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.id_ready    = 1'b1;
        start_reset();

        // Reset held 3 cycles, then release.
        tick(); tick(); tick();
        @(negedge clk);
        check_reset_outputs("reset");
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("first_req",      32'(bus.imem_req), 32'd1);
        check("first_req_addr", bus.imem_addr,     RST_PC);
        check("no_valid_c1",    32'(bus.if_valid), 32'd0);
        tick();
        @(negedge clk);
        check("no_valid_c2",    32'(bus.if_valid), 32'd0);
        // L=1, always ready: a word every cycle from the 3rd cycle on.
        for (int k = 3; k <= 10; k++) begin
            tick();
            @(negedge clk);
            check("stream_valid", 32'(bus.if_valid), 32'd1);
        end

        // Decode stalls 6 cycles: queue fills, requests stop, head holds.
        tick();
        bus.id_ready = 1'b0;
        for (int s = 1; s <= 6; s++) begin
            if (s > 1) tick();
            @(negedge clk);
            check("stall_no_req", 32'(bus.imem_req), 32'd0);
        end
        check("stall_valid", 32'(bus.if_valid), 32'd1);
        tick();
        bus.id_ready = 1'b1;
        repeat (10) tick();

        // Reset mid-stream with a request outstanding.
        start_reset();
        tick();
        @(negedge clk);
        check_reset_outputs("midreset");
        tick();
        rst = 1'b0;
        lat = 3;
        @(negedge clk);
        check("midreset_req",      32'(bus.imem_req), 32'd1);
        check("midreset_req_addr", bus.imem_addr,     RST_PC);

        // L=3: redirect to 0x103 one cycle after the request to 0x8.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_addr == 32'h8) found = 1'b1;
            else tick();
        end
        check("req_to_8_seen", 32'(found), 32'd1);
        tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h103;
        model_restart(32'h103);
        tick();
        bus.redirect = 1'b0;
        wait_req_seen("redirect_0x100_req", 20);
        repeat (15) tick();

        // Redirect with a full queue and a pop in the same cycle.
        lat = 1;
        repeat (5) tick();
        bus.id_ready = 1'b0;
        repeat (4) tick();
        bus.id_ready    = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        model_restart(32'h200);
        tick();
        bus.redirect = 1'b0;
        @(negedge clk);
        check("full_flush_valid",    32'(bus.if_valid), 32'd0);
        check("full_flush_req",      32'(bus.imem_req), 32'd1);
        check("full_flush_req_addr", bus.imem_addr,     32'h200);
        repeat (6) tick();

        // Redirect coincident with a response and a pop; target near the top
        // of the address space so the stream wraps through zero.
        tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFA;
        model_restart(32'hFFFF_FFFA);
        @(negedge clk);
        check("rsp_redirect_rvalid", 32'(bus.imem_rvalid), 32'd1);
        tick();
        bus.redirect = 1'b0;
        @(negedge clk);
        check("rsp_flush_valid",    32'(bus.if_valid), 32'd0);
        check("rsp_flush_req_addr", bus.imem_addr,     32'hFFFF_FFF8);
        repeat (10) tick();

        // Random latency, stalls, redirects and occasional resets.
        lat      = 0;
        rst_left = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) rst = 1'b0;
            end else if ($urandom_range(0, 599) == 0) begin
                start_reset();
                rst_left = int'($urandom_range(1, 2));
            end else begin
                bus.id_ready = ($urandom_range(0, 99) < 70);
                if ($urandom_range(0, 99) < 3) begin
                    bus.redirect    = 1'b1;
                    bus.redirect_pc = $urandom;
                    model_restart(bus.redirect_pc);
                end else begin
                    bus.redirect = 1'b0;
                end
            end
        end
        rst          = 1'b0;
        bus.redirect = 1'b0;
        bus.id_ready = 1'b1;
        lat          = 1;
        wait_req_seen("random_restart_req", 30);

        // Full throughput once memory latency is 1 and decode is always ready.
        repeat (10) tick();
        p0 = pops;
        repeat (20) tick();
        check("throughput", 32'((pops - p0) >= 19), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
